// File: rtl/sbox_engine.sv
// Loadable WIDTH-bit substitution box: bijectivity-checked run-time load, then
// forward/inverse lookups over a valid/ready stream with a registered result.
module sbox_engine #(
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld_start,
  input  logic             ld_valid,
  input  logic [WIDTH-1:0] ld_data,
  output logic             ld_ready,
  output logic             tbl_ok,
  output logic             tbl_err,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_inv,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  localparam int DEPTH = 2**WIDTH;
  localparam logic [WIDTH-1:0] ADDR_LAST = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ADDR_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2,
    ERR   = 2'd3
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [WIDTH-1:0] fwd_mem [DEPTH];
  logic [WIDTH-1:0] inv_mem [DEPTH];
  logic [DEPTH-1:0] occ;
  logic [WIDTH-1:0] ld_addr;

  logic             ld_acc;
  logic             ld_last;
  logic             dup_hit;
  logic             in_acc;
  logic             vld_p1;
  logic [WIDTH-1:0] out_data_p1;

  // ld_start always wins over a same-cycle load entry or lookup request
  assign ld_acc   = (state_q == LOAD) && ld_valid && !ld_start;
  assign ld_last  = (ld_addr == ADDR_LAST);
  assign dup_hit  = occ[ld_data];

  assign ld_ready = (state_q == LOAD);
  assign in_ready = (state_q == RUN) && !ld_start && (!vld_p1 || out_ready);
  assign in_acc   = in_valid && in_ready;

  assign out_valid = vld_p1;
  assign out_data  = out_data_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (ld_start) begin
      state_d = LOAD;
    end else if (ld_acc && ld_last) begin
      // The final entry's own duplicate check counts toward the verdict
      state_d = (!tbl_err && !dup_hit) ? RUN : ERR;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_addr <= '0;
      occ     <= '0;
      tbl_ok  <= 1'b0;
      tbl_err <= 1'b0;
    end else if (ld_start) begin
      ld_addr <= '0;
      occ     <= '0;
      tbl_ok  <= 1'b0;
      tbl_err <= 1'b0;
    end else if (ld_acc) begin
      occ[ld_data] <= 1'b1;
      ld_addr      <= ld_addr + ADDR_ONE;
      if (dup_hit) begin
        tbl_err <= 1'b1;
      end
      if (ld_last && !tbl_err && !dup_hit) begin
        tbl_ok <= 1'b1;
      end
    end
  end

  // Table contents are data only: no reset, written solely during LOAD
  always_ff @(posedge clk) begin
    if (ld_acc) begin
      fwd_mem[ld_addr] <= ld_data;
      inv_mem[ld_data] <= ld_addr;
    end
  end

  // ---- stage p0 -> p1: table read into the output register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1      <= 1'b0;
      out_data_p1 <= '0;
    end else begin
      if (ld_start) begin
        vld_p1 <= 1'b0;
      end else if (in_acc) begin
        vld_p1 <= 1'b1;
      end else if (out_ready) begin
        vld_p1 <= 1'b0;
      end
      if (in_acc) begin
        out_data_p1 <= in_inv ? inv_mem[in_data] : fwd_mem[in_data];
      end
    end
  end

endmodule

// File: tb/tb_sbox_engine.sv
// Directed bench for sbox_engine (WIDTH=9): load, lookup, back-pressure,
// load restart, duplicate detection and asynchronous reset.
module tb_sbox_engine;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ld_start = 1'b0;
  logic       ld_valid = 1'b0;
  logic [8:0] ld_data = '0;
  logic       ld_ready;
  logic       tbl_ok;
  logic       tbl_err;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [8:0] in_data = '0;
  logic       in_inv = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [8:0] out_data;

  int n_vec = 0;
  int n_err = 0;

  logic [8:0] tbl [512];

  sbox_engine #(.WIDTH(9)) dut (
    .clk(clk), .rst_n(rst_n),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_ready(ld_ready), .tbl_ok(tbl_ok), .tbl_err(tbl_err),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_inv(in_inv),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] inv_of(input logic [8:0] v);
    logic [8:0] r = '0;
    for (int i = 0; i < 512; i++) if (tbl[i] == v) r = 9'(i);
    return r;
  endfunction

  task automatic place(input int a, input logic [8:0] v);
    int j = 0;
    logic [8:0] t;
    for (int i = 0; i < 512; i++) if (tbl[i] == v) j = i;
    t = tbl[a]; tbl[a] = tbl[j]; tbl[j] = t;
  endtask

  task automatic build_shift();
    for (int i = 0; i < 512; i++) tbl[i] = 9'((i + 5) % 512);
  endtask

  // Bijection carrying the three known S9 anchor entries
  task automatic build_s9();
    for (int i = 0; i < 512; i++) tbl[i] = 9'(i) ^ 9'h0A5;
    place(0, 9'd167);
    place(1, 9'd239);
    place(511, 9'd461);
  endtask

  task automatic start_load();
    ld_start = 1'b1;
    @(posedge clk); #1;
    ld_start = 1'b0;
  endtask

  task automatic feed(input int first, input int count);
    for (int i = first; i < first + count; i++) begin
      ld_valid = 1'b1;
      ld_data  = tbl[i];
      @(posedge clk); #1;
    end
    ld_valid = 1'b0;
  endtask

  task automatic lookup(input logic inv, input logic [8:0] idx,
                        output logic [8:0] res, output logic got);
    got = 1'b0;
    res = '0;
    in_valid = 1'b1; in_inv = inv; in_data = idx; out_ready = 1'b1;
    for (int k = 0; k < 8 && !got; k++) begin
      #1 got = in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (got && out_valid) res = out_data;
    else got = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    @(posedge clk); @(posedge clk); #1;
    n_vec++;
    if ({ld_ready, tbl_ok, tbl_err, in_ready, out_valid, out_data} !== 14'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got %b required 0", {ld_ready, tbl_ok, tbl_err, in_ready, out_valid, out_data});
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b1;
    #1;
    n_vec++;
    if (in_ready !== 1'b0 || ld_ready !== 1'b0) begin
      n_err++;
      $display("FAIL empty_ready: in_ready %b ld_ready %b required 0 0", in_ready, ld_ready);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_load_shift();
    logic [8:0] r;
    logic g;
    build_shift();
    start_load();
    feed(0, 511);
    n_vec++;
    if (tbl_ok !== 1'b0 || ld_ready !== 1'b1) begin
      n_err++;
      $display("FAIL shift_pre_last: tbl_ok %b ld_ready %b required 0 1", tbl_ok, ld_ready);
    end
    feed(511, 1);
    n_vec++;
    if (tbl_ok !== 1'b1 || tbl_err !== 1'b0 || ld_ready !== 1'b0) begin
      n_err++;
      $display("FAIL shift_done: tbl_ok %b tbl_err %b ld_ready %b required 1 0 0", tbl_ok, tbl_err, ld_ready);
    end
    lookup(1'b0, 9'd0, r, g);
    n_vec++;
    if (!g || r !== 9'd5) begin n_err++; $display("FAIL shift_fwd0: got %0d (acc %b) required 5", r, g); end
    lookup(1'b0, 9'd511, r, g);
    n_vec++;
    if (!g || r !== 9'd4) begin n_err++; $display("FAIL shift_fwd511: got %0d (acc %b) required 4", r, g); end
    lookup(1'b1, 9'd5, r, g);
    n_vec++;
    if (!g || r !== 9'd0) begin n_err++; $display("FAIL shift_inv5: got %0d (acc %b) required 0", r, g); end
  endtask

  task automatic test_ld_start_restart();
    logic [8:0] r;
    logic g;
    for (int i = 0; i < 512; i++) tbl[i] = 9'(i);
    start_load();
    feed(0, 200);
    // restart with a same-cycle entry that must be ignored
    build_shift();
    ld_start = 1'b1; ld_valid = 1'b1; ld_data = 9'd77;
    @(posedge clk); #1;
    ld_start = 1'b0; ld_valid = 1'b0;
    n_vec++;
    if (ld_ready !== 1'b1 || tbl_ok !== 1'b0) begin
      n_err++;
      $display("FAIL restart_state: ld_ready %b tbl_ok %b required 1 0", ld_ready, tbl_ok);
    end
    feed(0, 512);
    n_vec++;
    if (tbl_ok !== 1'b1 || tbl_err !== 1'b0) begin
      n_err++;
      $display("FAIL restart_done: tbl_ok %b tbl_err %b required 1 0", tbl_ok, tbl_err);
    end
    lookup(1'b0, 9'd0, r, g);
    n_vec++;
    if (!g || r !== 9'd5) begin n_err++; $display("FAIL restart_fwd0: got %0d (acc %b) required 5", r, g); end
    lookup(1'b0, 9'd200, r, g);
    n_vec++;
    if (!g || r !== 9'd205) begin n_err++; $display("FAIL restart_fwd200: got %0d (acc %b) required 205", r, g); end
  endtask

  task automatic test_s9();
    logic [8:0] r;
    logic g;
    build_s9();
    start_load();
    feed(0, 512);
    n_vec++;
    if (tbl_ok !== 1'b1) begin n_err++; $display("FAIL s9_ok: got %b required 1", tbl_ok); end
    lookup(1'b0, 9'd1, r, g);
    n_vec++;
    if (!g || r !== 9'd239) begin n_err++; $display("FAIL s9_fwd1: got %0d (acc %b) required 239", r, g); end
    lookup(1'b1, 9'd461, r, g);
    n_vec++;
    if (!g || r !== 9'd511) begin n_err++; $display("FAIL s9_inv461: got %0d (acc %b) required 511", r, g); end
    lookup(1'b1, 9'd167, r, g);
    n_vec++;
    if (!g || r !== 9'd0) begin n_err++; $display("FAIL s9_inv167: got %0d (acc %b) required 0", r, g); end
  endtask

  task automatic test_back_to_back();
    logic [8:0] idx [6];
    idx[0] = 9'd2; idx[1] = 9'd3; idx[2] = 9'd100; idx[3] = 9'd300; idx[4] = 9'd510; idx[5] = 9'd64;
    out_ready = 1'b1; in_valid = 1'b1; in_inv = 1'b0; in_data = idx[0];
    for (int k = 0; k < 6; k++) begin
      #1;
      n_vec++;
      if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready%0d: got %b required 1", k, in_ready); end
      @(posedge clk); #1;
      n_vec++;
      if (out_valid !== 1'b1 || out_data !== tbl[idx[k]]) begin
        n_err++;
        $display("FAIL b2b_res%0d: valid %b data %0d required 1 %0d", k, out_valid, out_data, tbl[idx[k]]);
      end
      if (k < 5) in_data = idx[k + 1];
      else in_valid = 1'b0;
    end
    @(posedge clk); #1;
    n_vec++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_drain: out_valid %b required 0", out_valid); end
  endtask

  task automatic test_backpressure();
    logic [8:0] exp_a;
    logic [8:0] exp_b;
    exp_a = tbl[20];
    exp_b = inv_of(9'd21);
    out_ready = 1'b0; in_valid = 1'b1; in_inv = 1'b0; in_data = 9'd20;
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_first_ready: got %b required 1", in_ready); end
    @(posedge clk); #1;
    in_inv = 1'b1; in_data = 9'd21;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_vec++;
      if (out_valid !== 1'b1 || out_data !== exp_a || in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL bp_hold%0d: valid %b data %0d in_ready %b required 1 %0d 0", k, out_valid, out_data, in_ready, exp_a);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_ready: got %b required 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_vec++;
    if (out_valid !== 1'b1 || out_data !== exp_b) begin
      n_err++;
      $display("FAIL bp_second: valid %b data %0d required 1 %0d", out_valid, out_data, exp_b);
    end
    @(posedge clk); #1;
    n_vec++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_drain: out_valid %b required 0", out_valid); end
  endtask

  task automatic test_ld_start_vs_lookup();
    out_ready = 1'b0; in_valid = 1'b1; in_inv = 1'b0; in_data = 9'd1;
    @(posedge clk); #1;
    n_vec++;
    if (out_valid !== 1'b1 || out_data !== 9'd239) begin
      n_err++;
      $display("FAIL race_pending: valid %b data %0d required 1 239", out_valid, out_data);
    end
    ld_start = 1'b1; out_ready = 1'b1; in_data = 9'd2;
    #1;
    n_vec++;
    if (in_ready !== 1'b0) begin n_err++; $display("FAIL race_in_ready: got %b required 0", in_ready); end
    @(posedge clk); #1;
    ld_start = 1'b0; in_valid = 1'b0;
    n_vec++;
    if (out_valid !== 1'b0 || ld_ready !== 1'b1 || tbl_ok !== 1'b0) begin
      n_err++;
      $display("FAIL race_after: valid %b ld_ready %b tbl_ok %b required 0 1 0", out_valid, ld_ready, tbl_ok);
    end
  endtask

  task automatic test_reset_midload();
    // engine is in LOAD at address 0 here
    feed(0, 300);
    in_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({ld_ready, tbl_ok, tbl_err, in_ready, out_valid, out_data} !== 14'd0) begin
      n_err++;
      $display("FAIL midreset_outputs: got %b required 0", {ld_ready, tbl_ok, tbl_err, in_ready, out_valid, out_data});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    n_vec++;
    if (in_ready !== 1'b0 || ld_ready !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_empty: in_ready %b ld_ready %b required 0 0", in_ready, ld_ready);
    end
    @(posedge clk); #1;
    n_vec++;
    if (in_ready !== 1'b0 || ld_ready !== 1'b0 || tbl_ok !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_stay: in_ready %b ld_ready %b tbl_ok %b required 0 0 0", in_ready, ld_ready, tbl_ok);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_dup_err();
    for (int i = 0; i < 512; i++) tbl[i] = 9'(i);
    tbl[3] = 9'd7;
    tbl[10] = 9'd7;
    start_load();
    feed(0, 512);
    n_vec++;
    if (tbl_err !== 1'b1 || tbl_ok !== 1'b0 || ld_ready !== 1'b0) begin
      n_err++;
      $display("FAIL dup_verdict: tbl_err %b tbl_ok %b ld_ready %b required 1 0 0", tbl_err, tbl_ok, ld_ready);
    end
    in_valid = 1'b1; out_ready = 1'b1; in_data = 9'd3;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_vec++;
      if (in_ready !== 1'b0) begin n_err++; $display("FAIL dup_in_ready%0d: got %b required 0", k, in_ready); end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    n_vec++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL dup_no_result: out_valid %b required 0", out_valid); end
    start_load();
    n_vec++;
    if (tbl_err !== 1'b0 || ld_ready !== 1'b1) begin
      n_err++;
      $display("FAIL dup_cleared: tbl_err %b ld_ready %b required 0 1", tbl_err, ld_ready);
    end
  endtask

  initial begin
    test_reset();
    test_load_shift();
    test_ld_start_restart();
    test_s9();
    test_back_to_back();
    test_backpressure();
    test_ld_start_vs_lookup();
    test_reset_midload();
    test_dup_err();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sbox_engine.md
# sbox_engine

Loadable, parametrised substitution-box engine: the successor to the fixed 9-bit S9 lookup ROM. It holds a WIDTH-bit bijective table loaded at run time, checks bijectivity during load, and serves forward or inverse lookups through a valid/ready stream with a registered output. It sits between the cipher round datapath and the key/config loader.

## Interface
- WIDTH, 9: symbol width in bits; table depth DEPTH = 2**WIDTH (derived, not overridable).
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ld_start  in  1  pulse: discard the current table and begin a new load.
- ld_valid  in  1  load entry valid.
- ld_data  in  WIDTH  value for the current load address.
- ld_ready  out  1  engine accepts load entries (high only in LOAD).
- tbl_ok  out  1  table fully loaded and bijective.
- tbl_err  out  1  duplicate value detected in the last load (sticky until next ld_start or reset).
- in_valid  in  1  lookup request valid.
- in_ready  out  1  lookup request accepted this cycle when in_valid is also high.
- in_data  in  WIDTH  lookup index.
- in_inv  in  1  0 = forward (fwd[x]), 1 = inverse (inv[x]).
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  WIDTH  lookup result.

## Operation
- Storage: fwd[DEPTH], inv[DEPTH] (WIDTH bits each); occupancy vector occ[DEPTH]; load address counter ld_addr (WIDTH bits).
- States: EMPTY (reset), LOAD, RUN, ERR.
- ld_start in any state, including LOAD: go to LOAD next cycle; ld_addr = 0, occ cleared, tbl_ok = 0, tbl_err = 0, out_valid = 0 (a pending result is dropped).
- In LOAD, an entry is accepted on ld_valid && ld_ready: fwd[ld_addr] = ld_data; inv[ld_data] = ld_addr; occ[ld_data] = 1; if occ[ld_data] was already 1, set tbl_err; ld_addr increments.
- When the entry at ld_addr = DEPTH-1 is accepted: go to RUN with tbl_ok = 1 if no duplicate was seen (including on this final entry), otherwise go to ERR with tbl_err = 1. ld_addr wraps to 0. Further ld_valid is ignored.
- in_ready = (state == RUN) && !ld_start && (!out_valid || out_ready). It is never high in EMPTY, LOAD or ERR.
- On an accepted lookup: out_data = in_inv ? inv[in_data] : fwd[in_data]; out_valid = 1.
- out_valid clears on out_ready when no new request is accepted in the same cycle.
- out_data holds its value while out_valid && !out_ready.
- ERR is left only by ld_start or reset; contents are retained but never served.

## Timing
- Reset values: state EMPTY; ld_ready 0, tbl_ok 0, tbl_err 0, in_ready 0, out_valid 0, out_data 0; ld_addr 0; occ cleared. Table contents need not be reset.
- Load: one entry per cycle, so a full load takes DEPTH accepted cycles. tbl_ok or tbl_err is asserted the cycle after the final accept.
- Lookup latency is 1 cycle (accept at edge N, out_valid at N+1). Full throughput of one result per cycle holds while out_ready stays high.
- Back-pressure: with out_valid && !out_ready, in_ready is low and out_data is stable.
- Simultaneous ld_start and in_valid: ld_start wins and the request is not accepted.
- Simultaneous ld_start and ld_valid: the entry is ignored and the load restarts at address 0.
- Reset asserted mid-load or mid-lookup: outputs go to reset values immediately (asynchronous); the engine resumes in EMPTY.

## Test plan
- Reset, then load fwd[i] = (i+5) mod 512 (WIDTH=9) -> tbl_ok = 1 one cycle after the 512th accept; lookup fwd 0 -> 5, fwd 511 -> 4, inv 5 -> 0.
- Load the S9 permutation (fwd[0]=167, fwd[1]=239, fwd[511]=461) -> fwd 1 -> 239, inv 461 -> 511, inv 167 -> 0; back-to-back requests give one result per cycle.
- Load with ld_data = 7 at addresses 3 and 10 -> ERR state, tbl_err = 1, tbl_ok = 0, in_ready stays 0. A subsequent ld_start clears tbl_err.
- Hold out_ready low for 4 cycles with in_valid high -> out_data stable, in_ready 0, no requests lost. On release, results arrive in request order.
- Assert ld_start at ld_addr = 200, and separately in the same cycle as in_valid during RUN -> load restarts at address 0, the request is not accepted, and a pending out_valid drops.
- Deassert rst_n mid-load at ld_addr = 300 -> all outputs are 0 immediately; after release the state is EMPTY and in_ready is 0.
